// File: rtl/key_encode83_pkg.sv
// Shared definitions for the push-button key encoder: FSM state encodings
// and the all-released level of the active-low key bus.
package key_encode83_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   localparam logic [7:0] KEY_IDLE = 8'hFF;

endpackage

// File: rtl/key_encode83_prio.sv
// Combinational 8-to-3 priority encoder for active-low keys. Bit 7 has
// highest priority and encodes to 3'b000; bit 0 encodes to 3'b111.
module prio_encode83
   import key_encode83_pkg::*;
(
   input  logic [7:0] key_n,
   output logic [2:0] code,
   output logic       found
);

   // Ascending scan: the last low bit seen (the highest index) wins.
   always_comb begin
      code = 3'b000;
      for (int i = 0; i < 8; i++) begin
         if (!key_n[i]) code = 3'(7 - i);
      end
      found = (key_n != KEY_IDLE);
   end

endmodule

// File: rtl/key_encode83.sv
// Debounced eight-button key encoder: two-flop synchronizer, press/release
// debounce FSM, and a one-cycle valid strobe per accepted press.
module key_encode83
   import key_encode83_pkg::*;
#(
   parameter int DB_CYCLES = 500000,
   parameter int CNT_W     = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] key_n,
   output logic [2:0] code,
   output logic       valid,
   output logic       key_down,
   output logic       multi
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [7:0]       sync_p0, sync_p1;
   logic [7:0]       snap, snap_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   state_t           state, state_nxt;
   logic [2:0]       enc, code_nxt;
   logic             any, valid_nxt, key_down_nxt, multi_nxt;

   function automatic logic multi_low(input logic [7:0] k);
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (!k[i]) n++;
      end
      return (n > 1);
   endfunction

   // Encoder watches the synchronized bus; at acceptance sync equals snap.
   prio_encode83 u_prio (
      .key_n (sync_p1),
      .code  (enc),
      .found (any)
   );

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      snap_nxt     = snap;
      code_nxt     = code;
      multi_nxt    = multi;
      key_down_nxt = key_down;
      valid_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (any) begin
               state_nxt = PRESS_DB;
               snap_nxt  = sync_p1;
               cnt_nxt   = '0;
            end
         end
         PRESS_DB: begin
            if (!any) begin
               state_nxt = IDLE;
            end else if (sync_p1 != snap) begin
               snap_nxt = sync_p1;
               cnt_nxt  = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt    = HELD;
               valid_nxt    = 1'b1;
               code_nxt     = enc;
               multi_nxt    = multi_low(snap);
               key_down_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (!any) begin
               state_nxt = REL_DB;
               cnt_nxt   = '0;
            end
         end
         REL_DB: begin
            if (any) begin
               state_nxt = HELD;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt    = IDLE;
               key_down_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0  <= KEY_IDLE;
         sync_p1  <= KEY_IDLE;
         state    <= IDLE;
         cnt      <= '0;
         snap     <= KEY_IDLE;
         code     <= 3'b000;
         valid    <= 1'b0;
         key_down <= 1'b0;
         multi    <= 1'b0;
      end else begin
         sync_p0  <= key_n;
         sync_p1  <= sync_p0;
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         snap     <= snap_nxt;
         code     <= code_nxt;
         valid    <= valid_nxt;
         key_down <= key_down_nxt;
         multi    <= multi_nxt;
      end
   end

endmodule

// File: doc/key_encode83.md
Name: key_encode83

Overview:
- Reads eight active-low push-buttons and produces a debounced 3-bit key code with a one-cycle valid strobe.
- Inverse of the board's 3-8 LED decoder. Key bit 7 maps to code 3'b000 and key bit 0 maps to code 3'b111, so a single-key code fed back into the decoder lights the LED at the pressed position.
- Sits between the board button pins and downstream logic such as display or mode selection.

Parameters:
- DB_CYCLES, 500000: stable-input cycles needed to accept a press or a release (10 ms at 50 MHz). Legal range is 2..2^CNT_W-1.
- CNT_W, 20: width of the debounce counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_n  input  8  raw button levels, active-low, asynchronous to clk.
- code  output  3  encoded key, held until the next accepted press.
- valid  output  1  one-cycle pulse when a new press is accepted.
- key_down  output  1  high while an accepted press is held, including during release debounce.
- multi  output  1  at acceptance, more than one key was low. Held with code.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high, ports named clk and rst.
  - On rst: code=3'b000, valid=0, key_down=0, multi=0, state=IDLE, counter=0, both synchronizer stages=8'hFF.
  - Reset mid-operation aborts immediately and produces no valid.
- Synchronizer:
  - Two-flop synchronizer on key_n gives sync[7:0].
  - any = (sync != 8'hFF).
- Priority encode (combinational on the debounced snapshot):
  - Scan from bit 7 down to bit 0. The first low bit i gives enc = 7 - i.
  - Only meaningful when any=1.
- States are IDLE, PRESS_DB, HELD, REL_DB.
- IDLE:
  - If any=1: go to PRESS_DB, snap<=sync, cnt<=0.
- PRESS_DB:
  - If sync==8'hFF: go to IDLE (bounce rejected).
  - Else if sync!=snap: snap<=sync, cnt<=0.
  - Else if cnt==DB_CYCLES-1: go to HELD; valid<=1 for one cycle; code<=enc(snap); multi<=(popcount of ~snap)>1; key_down<=1.
  - Else cnt<=cnt+1.
- HELD:
  - If sync==8'hFF: go to REL_DB, cnt<=0.
  - Changes to the key pattern while any key stays low are ignored: no re-encode, no valid.
- REL_DB:
  - If any=1: go to HELD, cnt<=0.
  - Else if cnt==DB_CYCLES-1: go to IDLE, key_down<=0.
  - Else cnt<=cnt+1.
- Latency:
  - key_n first sampled low at edge E0 and stable thereafter: valid is high during the cycle after edge E0+DB_CYCLES+2.
  - key_down falls DB_CYCLES+2 edges after the release is first sampled.
- Output holding:
  - code and multi keep their values through release and IDLE until the next acceptance.
  - valid is never high for two consecutive cycles.
  - The counter saturates by construction and cannot wrap, because every state leaves or resets at DB_CYCLES-1.

Decomposition:
- Shared include file: state encodings (IDLE=2'd0, PRESS_DB=2'd1, HELD=2'd2, REL_DB=2'd3) and KEY_IDLE=8'hFF.
- One sub-module, prio_encode83: purely combinational, 8-bit active-low in, 3-bit code out plus a found flag.
- Synchronizer, FSM and counter stay in key_encode83.

Test Plan (DB_CYCLES=4, CNT_W=3):
1. Reset: assert rst with key_n=8'h00 -> code=000, valid=0, key_down=0, multi=0; no valid for 3 cycles after release of rst with key_n=8'hFF.
2. Single press: key_n=8'b1101_1111 stable from E0 -> valid high exactly one cycle after edge E0+6, code=3'b010, multi=0, key_down=1.
3. Bounce: key_n toggles 8'b1111_1110 / 8'hFF every 2 cycles for 20 cycles -> valid stays 0; key_down stays 0.
4. Multi-key: key_n=8'b1011_1011 -> code=3'b001, multi=1, single valid pulse.
5. Release and re-press: after test 2, key_n=8'hFF -> key_down falls at release+6. Then key_n=8'b1111_1110 -> code=3'b111 with new valid. A 2-cycle 8'hFF glitch inside HELD produces no new valid.
6. Reset in HELD: assert rst while key held -> outputs cleared immediately. Deassert with key still low -> fresh valid after full DB_CYCLES+2 latency.
